reg_file_2r1w_clr: RTL and testbench

//  Parametrised register file: one write port, two independent read ports, registered read data.
//  A hardware clear sequencer fills every entry with CLR_VALUE after reset or on request.

---
 rtl/reg_file_2r1w_clr_if.sv | 24 ++
 rtl/reg_file_2r1w_clr.sv | 67 ++++++
 tb/tb_reg_file_2r1w_clr.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/reg_file_2r1w_clr_if.sv
// reg_file_2r1w_clr_if: control, write and dual-read bus of the clearable register file
interface reg_file_2r1w_clr_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
);
   logic                  clr_req;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [ADDR_WIDTH-1:0] r_addr_a;
   logic [ADDR_WIDTH-1:0] r_addr_b;
   logic [DATA_WIDTH-1:0] r_data_a;
   logic [DATA_WIDTH-1:0] r_data_b;
   logic                  ready;
   logic                  wr_drop;
   modport master (
      output clr_req, wr_en, w_addr, w_data, r_addr_a, r_addr_b,
      input  r_data_a, r_data_b, ready, wr_drop
   );
   modport slave (
      input  clr_req, wr_en, w_addr, w_data, r_addr_a, r_addr_b,
      output r_data_a, r_data_b, ready, wr_drop
   );
endinterface

// File: rtl/reg_file_2r1w_clr.sv
// reg_file_2r1w_clr: 2-read/1-write register file with hardware clear sequencer; define REG_FILE_BYPASS_EN for write-first reads
module reg_file_2r1w_clr #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 2,
   parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
   input logic                clk,
   input logic                reset_n,
   reg_file_2r1w_clr_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  clr_we, rdy, wr_ok;
   logic [DATA_WIDTH-1:0] rd_a, rd_b;
   // state register; reset always restarts the clear sequence
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= CLEAR;
      else          state <= state_nxt;
   end
   // next state: clear runs to the last entry, clr_req only honoured in IDLE
   always_comb begin
      state_nxt = state == CLEAR ? (clr_addr == ADDR_WIDTH'(DEPTH - 1) ? IDLE : CLEAR)
                                 : (bus.clr_req ? CLEAR : IDLE);
   end
   // state-decoded outputs
   always_comb begin
      rdy    = state == IDLE;
      clr_we = state == CLEAR;
   end
   assign wr_ok     = bus.wr_en && rdy && !bus.clr_req;
   assign bus.ready = rdy;
   // clear pointer walks while clearing and parks at 0 otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) clr_addr <= '0;
      else          clr_addr <= clr_we ? clr_addr + 1'b1 : '0;
   end
   // storage array, initialised only by the clear sequencer
   always_ff @(posedge clk) begin
      if (clr_we)     mem[clr_addr]   <= CLR_VALUE;
      else if (wr_ok) mem[bus.w_addr] <= bus.w_data;
   end
   // read data selection; CLR_VALUE is returned while the array is not valid
   always_comb begin
`ifdef REG_FILE_BYPASS_EN
      rd_a = !rdy ? CLR_VALUE : (wr_ok && bus.w_addr == bus.r_addr_a) ? bus.w_data : mem[bus.r_addr_a];
      rd_b = !rdy ? CLR_VALUE : (wr_ok && bus.w_addr == bus.r_addr_b) ? bus.w_data : mem[bus.r_addr_b];
`else
      rd_a = !rdy ? CLR_VALUE : mem[bus.r_addr_a];
      rd_b = !rdy ? CLR_VALUE : mem[bus.r_addr_b];
`endif
   end
   // registered read ports and dropped-write pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.r_data_a <= '0;
         bus.r_data_b <= '0;
         bus.wr_drop  <= 1'b0;
      end else begin
         bus.r_data_a <= rd_a;
         bus.r_data_b <= rd_b;
         bus.wr_drop  <= bus.wr_en && !(rdy && !bus.clr_req);
      end
   end
endmodule

// File: tb/tb_reg_file_2r1w_clr.sv
// tb_reg_file_2r1w_clr: directed self-checking bench for reg_file_2r1w_clr with CLR_VALUE=8'hA5
module tb_reg_file_2r1w_clr;
   localparam logic [7:0] CV = 8'hA5;
`ifdef REG_FILE_BYPASS_EN
   localparam logic [7:0] SAME = 8'h77;
`else
   localparam logic [7:0] SAME = 8'hA5;
`endif
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   reg_file_2r1w_clr_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();
   reg_file_2r1w_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .CLR_VALUE(CV)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic c, input logic w, input logic [1:0] wa, input logic [7:0] wd,
                        input logic [1:0] ra, input logic [1:0] rb);
      bus.clr_req  = c;
      bus.wr_en    = w;
      bus.w_addr   = wa;
      bus.w_data   = wd;
      bus.r_addr_a = ra;
      bus.r_addr_b = rb;
   endtask
   initial begin
      drive(0, 0, 0, 0, 0, 3);
      step();
      step();
      chk("rst_ready", bus.ready, 0);
      chk("rst_rda", bus.r_data_a, 0);
      chk("rst_rdb", bus.r_data_b, 0);
      chk("rst_drop", bus.wr_drop, 0);
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("init_ready%0d", i), bus.ready, i == 4);
         chk($sformatf("init_rda%0d", i), bus.r_data_a, CV);
      end
      drive(0, 0, 0, 0, 0, 3);
      step();
      chk("t1_a0", bus.r_data_a, CV);
      chk("t1_b3", bus.r_data_b, CV);
      drive(0, 0, 0, 0, 1, 2);
      step();
      chk("t1_a1", bus.r_data_a, CV);
      chk("t1_b2", bus.r_data_b, CV);
      drive(0, 1, 2, 8'h3C, 0, 0);
      step();
      chk("t2_drop", bus.wr_drop, 0);
      drive(0, 0, 0, 0, 2, 1);
      step();
      chk("t2_a2", bus.r_data_a, 8'h3C);
      chk("t2_b1", bus.r_data_b, CV);
      drive(0, 1, 1, 8'h77, 1, 1);
      step();
      chk("t3_same_a", bus.r_data_a, SAME);
      chk("t3_same_b", bus.r_data_b, SAME);
      drive(0, 0, 0, 0, 1, 1);
      step();
      chk("t3_next_a", bus.r_data_a, 8'h77);
      chk("t3_next_b", bus.r_data_b, 8'h77);
      drive(1, 1, 0, 8'h11, 0, 2);
      step();
      chk("t4_drop", bus.wr_drop, 1);
      chk("t4_ready0", bus.ready, 0);
      chk("t4_rda0", bus.r_data_a, CV);
      chk("t4_rdb0", bus.r_data_b, 8'h3C);
      drive(0, 0, 0, 0, 0, 2);
      step();
      chk("t4_drop_end", bus.wr_drop, 0);
      chk("t4_ready1", bus.ready, 0);
      bus.clr_req = 1'b1;
      step();
      chk("t4_ready2", bus.ready, 0);
      bus.clr_req = 1'b0;
      step();
      chk("t4_ready3", bus.ready, 0);
      step();
      chk("t4_ready4", bus.ready, 1);
      step();
      chk("t4_a0", bus.r_data_a, CV);
      chk("t4_b2", bus.r_data_b, CV);
      chk("t4_ready5", bus.ready, 1);
      drive(0, 1, 2, 8'h3C, 0, 0);
      step();
      drive(1, 0, 0, 0, 2, 2);
      step();
      chk("t5_rda_idle", bus.r_data_a, 8'h3C);
      chk("t5_ready0", bus.ready, 0);
      bus.clr_req = 1'b0;
      step();
      chk("t5_rda_clr", bus.r_data_a, CV);
      chk("t5_drop_none", bus.wr_drop, 0);
      drive(0, 1, 0, 8'h5A, 2, 0);
      for (int i = 2; i <= 4; i++) begin
         step();
         chk($sformatf("t5_drop%0d", i), bus.wr_drop, 1);
         chk($sformatf("t5_ready%0d", i), bus.ready, i == 4);
      end
      drive(0, 0, 0, 0, 0, 2);
      step();
      chk("t5_drop_end", bus.wr_drop, 0);
      chk("t5_a0", bus.r_data_a, CV);
      chk("t5_b2", bus.r_data_b, CV);
      drive(0, 1, 3, 8'hC3, 3, 3);
      step();
      drive(0, 0, 0, 0, 3, 3);
      step();
      chk("t6_pre_a3", bus.r_data_a, 8'hC3);
      bus.clr_req = 1'b1;
      step();
      bus.clr_req = 1'b0;
      step();
      step();
      reset_n = 1'b0;
      #1;
      chk("t6_rst_ready", bus.ready, 0);
      chk("t6_rst_rda", bus.r_data_a, 0);
      chk("t6_rst_rdb", bus.r_data_b, 0);
      step();
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("t6_ready%0d", i), bus.ready, i == 4);
      end
      step();
      chk("t6_a3", bus.r_data_a, CV);
      chk("t6_b3", bus.r_data_b, CV);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
